dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache controller. It sits between the MEM pipeline stage and the byte-addressed data memory. It serves read hits in the same cycle. On read misses, uncached accesses and all stores, it sequences the memory's MemRead/MemWrite/MemValid handshake and stalls the pipeline until the access completes. Line size is one 32-bit word; byte/half extraction and sign extension for hits and fills are done here.

---
 rtl/dcache_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits return in the same cycle; misses, uncached reads and stores
// go through the memory handshake and stall the pipeline until MemValid.
module dcache_ctrl #(
    parameter int unsigned SETS      = 256,
    parameter int unsigned ADDR_BITS = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqRead,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddress,
    input  logic [31:0] ReqWriteData,
    input  logic [1:0]  SizeSrc,
    input  logic        LoadSign,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic [1:0]  MemSize,
    output logic        MemLoadSign,
    input  logic [31:0] MemData,
    input  logic        MemValid,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
);
    localparam int unsigned INDEX_BITS = $clog2(SETS);
    localparam int unsigned TAG_BITS   = ADDR_BITS - INDEX_BITS - 2;

    typedef enum logic [1:0] {StIdle, StFill, StUncachedRd, StWrite} state_e;

    state_e state_q, state_d;

    logic [SETS-1:0]     valid_q;
    logic [TAG_BITS-1:0] tag_q  [SETS];
    logic [31:0]         data_q [SETS];

    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        mem_rd_q, mem_wr_q, mem_sign_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [1:0]  mem_size_q;

    logic [1:0]            off;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [31:0]           line;
    logic                  aligned, hit, req_valid;
    logic                  stall_c, hit_inc, miss_inc, fill_en, merge_en;
    logic [31:0]           rdata_c, wshift, merged;
    logic [3:0]            be;

    assign off   = ReqAddress[1:0];
    assign index = ReqAddress[INDEX_BITS+1:2];
    assign tag   = ReqAddress[ADDR_BITS-1:INDEX_BITS+2];
    assign line  = data_q[index];

    assign aligned = ((SizeSrc == 2'b00) && (off == 2'b00)) ||
                     ((SizeSrc == 2'b01) && !off[0]) ||
                     (SizeSrc == 2'b10);
    assign hit       = aligned && valid_q[index] && (tag_q[index] == tag);
    assign req_valid = (ReqRead || ReqWrite) && (SizeSrc != 2'b11);

    // Shift the addressed lane down, keep 8/16/32 bits and extend.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] o,
                                            input logic [1:0] size, input logic sgn);
        logic [31:0] lane;
        lane = w >> {o, 3'b000};
        case (size)
            2'b00:   extract = lane;
            2'b01:   extract = {{16{sgn & lane[15]}}, lane[15:0]};
            2'b10:   extract = {{24{sgn & lane[7]}}, lane[7:0]};
            default: extract = '0;
        endcase
    endfunction

    // Byte-lane merge of a store into the resident line.
    always_comb begin
        be = 4'b0000;
        case (SizeSrc)
            2'b00:   be = 4'b1111;
            2'b01:   be = 4'b0011 << off;
            2'b10:   be = 4'b0001 << off;
            default: be = 4'b0000;
        endcase
        wshift = ReqWriteData << {off, 3'b000};
        merged = line;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wshift[8*i +: 8];
        end
    end

    // Next-state, stall, read-data and update enables.
    always_comb begin
        state_d  = state_q;
        stall_c  = 1'b0;
        rdata_c  = '0;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        fill_en  = 1'b0;
        merge_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (ReqWrite) begin
                        stall_c = 1'b1;
                        state_d = StWrite;
                    end else if (hit) begin
                        rdata_c = extract(line, off, SizeSrc, LoadSign);
                        hit_inc = 1'b1;
                    end else begin
                        stall_c  = 1'b1;
                        miss_inc = 1'b1;
                        state_d  = aligned ? StFill : StUncachedRd;
                    end
                end
            end
            StFill: begin
                stall_c = ~MemValid;
                if (MemValid) begin
                    fill_en = 1'b1;
                    rdata_c = extract(MemData, off, SizeSrc, LoadSign);
                    state_d = StIdle;
                end
            end
            StUncachedRd: begin
                stall_c = ~MemValid;
                if (MemValid) begin
                    rdata_c = MemData;
                    state_d = StIdle;
                end
            end
            StWrite: begin
                stall_c = ~MemValid;
                if (MemValid) begin
                    merge_en = hit;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, valid bits, counters and the registered memory request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= 2'b00;
            mem_sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
            if (fill_en)  valid_q[index] <= 1'b1;
            if (state_q == StIdle && state_d != StIdle) begin
                // Fills always fetch the whole aligned word.
                mem_rd_q    <= (state_d != StWrite);
                mem_wr_q    <= (state_d == StWrite);
                mem_addr_q  <= (state_d == StFill) ? {ReqAddress[31:2], 2'b00} : ReqAddress;
                mem_wdata_q <= (state_d == StWrite) ? ReqWriteData : '0;
                mem_size_q  <= (state_d == StFill) ? 2'b00 : SizeSrc;
                mem_sign_q  <= (state_d == StUncachedRd) ? LoadSign : 1'b0;
            end else if (state_q != StIdle && MemValid) begin
                mem_rd_q    <= 1'b0;
                mem_wr_q    <= 1'b0;
                mem_addr_q  <= '0;
                mem_wdata_q <= '0;
                mem_size_q  <= 2'b00;
                mem_sign_q  <= 1'b0;
            end
        end
    end

    // Tag and data storage need no reset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if (rst_n && fill_en) begin
            tag_q[index]  <= tag;
            data_q[index] <= MemData;
        end else if (rst_n && merge_en) begin
            data_q[index] <= merged;
        end
    end

    assign Stall        = rst_n & stall_c;
    assign ReadData     = rst_n ? rdata_c : '0;
    assign MemRead      = mem_rd_q;
    assign MemWrite     = mem_wr_q;
    assign MemAddress   = mem_addr_q;
    assign MemWriteData = mem_wdata_q;
    assign MemSize      = mem_size_q;
    assign MemLoadSign  = mem_sign_q;
    assign HitCount     = hit_cnt_q;
    assign MissCount    = miss_cnt_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: table of requests with expected memory
// traffic and load results, plus hand-written reset and counter sequences.
module tb_dcache_ctrl;
    localparam int KNone = 0;
    localparam int KRd   = 1;
    localparam int KWr   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ReqRead, ReqWrite, LoadSign, MemValid;
    logic [31:0] ReqAddress, ReqWriteData, MemData;
    logic [1:0]  SizeSrc;
    logic [31:0] ReadData, MemAddress, MemWriteData, HitCount, MissCount;
    logic        Stall, MemRead, MemWrite, MemLoadSign;
    logic [1:0]  MemSize;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_id   = -1;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sgn;
        int          lat;
        logic [31:0] mdata;
        int          kind;
        logic [31:0] maddr;
        logic [1:0]  msize;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        int          kind;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    dcache_ctrl #(.SETS(256), .ADDR_BITS(17)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ReqRead      (ReqRead),
        .ReqWrite     (ReqWrite),
        .ReqAddress   (ReqAddress),
        .ReqWriteData (ReqWriteData),
        .SizeSrc      (SizeSrc),
        .LoadSign     (LoadSign),
        .ReadData     (ReadData),
        .Stall        (Stall),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemSize      (MemSize),
        .MemLoadSign  (MemLoadSign),
        .MemData      (MemData),
        .MemValid     (MemValid),
        .HitCount     (HitCount),
        .MissCount    (MissCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got 0x%08h, expected 0x%08h", cur_id, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size,
                                input logic sgn, input int lat, input logic [31:0] mdata,
                                input int kind, input logic [31:0] maddr,
                                input logic [1:0] msize, input logic [31:0] rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.size = size; v.sgn = sgn;
        v.lat = lat; v.mdata = mdata; v.kind = kind; v.maddr = maddr; v.msize = msize;
        v.rdata = rdata;
        return v;
    endfunction

    task automatic idle_inputs();
        ReqRead = 1'b0; ReqWrite = 1'b0; ReqAddress = '0; ReqWriteData = '0;
        SizeSrc = 2'b00; LoadSign = 1'b0; MemValid = 1'b0; MemData = '0;
    endtask

    // Drive one request, act as memory when a strobe shows up, check the result.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   waits = 0;
        int   seen  = KNone;
        bit   done  = 1'b0;
        ReqRead = v.rd; ReqWrite = v.wr; ReqAddress = v.addr; ReqWriteData = v.wdata;
        SizeSrc = v.size; LoadSign = v.sgn;
        sb_q.push_back('{rdata: v.rdata, kind: v.kind});
        for (int iter = 0; iter < 20 && !done; iter++) begin
            @(negedge clk);
            if (!Stall) begin
                done = 1'b1;
            end else if (MemRead || MemWrite) begin
                if (seen == KNone) begin
                    seen = MemWrite ? KWr : KRd;
                    check("mem_addr", MemAddress, v.maddr);
                    check("mem_size", {30'd0, MemSize}, {30'd0, v.msize});
                    if (MemWrite) check("mem_wdata", MemWriteData, v.wdata);
                end
                if (waits >= v.lat) begin
                    MemValid = 1'b1;
                    MemData  = v.mdata;
                    #1;
                    check("stall_release", {31'd0, Stall}, 32'd0);
                    done = 1'b1;
                end else begin
                    waits++;
                end
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d timeout: got stall after 20 cycles, expected completion", cur_id);
        end
        e = sb_q.pop_front();
        check("rdata", ReadData, e.rdata);
        check("mem_kind", 32'(seen), 32'(e.kind));
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_memread", {31'd0, MemRead}, 32'd0);
        check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        check("rst_hits", HitCount, 32'd0);
        check("rst_misses", MissCount, 32'd0);
        check("rst_rdata", ReadData, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        //              rd wr addr         wdata         sz   s lat mdata         kind  maddr        msz   rdata
        vecs.push_back(mk(1, 0, 32'h100, 32'h0, 2'b00, 0, 2, 32'hDEADBEEF, KRd,  32'h100, 2'b00, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 32'h100, 32'h0, 2'b00, 0, 0, 32'h0,        KNone, 32'h0,  2'b00, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 32'h200, 32'h0, 2'b00, 0, 0, 32'h80FF7F01, KRd,  32'h200, 2'b00, 32'h80FF7F01));
        vecs.push_back(mk(1, 0, 32'h203, 32'h0, 2'b10, 1, 0, 32'h0,        KNone, 32'h0,  2'b00, 32'hFFFFFF80));
        vecs.push_back(mk(1, 0, 32'h201, 32'h0, 2'b10, 0, 0, 32'h0,        KNone, 32'h0,  2'b00, 32'h0000007F));
        vecs.push_back(mk(1, 0, 32'h202, 32'h0, 2'b01, 1, 0, 32'h0,        KNone, 32'h0,  2'b00, 32'hFFFF80FF));
        vecs.push_back(mk(0, 1, 32'h202, 32'hAA, 2'b10, 0, 1, 32'h0,       KWr,  32'h202, 2'b10, 32'h0));
        vecs.push_back(mk(1, 0, 32'h200, 32'h0, 2'b00, 0, 0, 32'h0,        KNone, 32'h0,  2'b00, 32'h80AA7F01));
        vecs.push_back(mk(0, 1, 32'h300, 32'h12345678, 2'b00, 0, 0, 32'h0, KWr,  32'h300, 2'b00, 32'h0));
        vecs.push_back(mk(1, 0, 32'h300, 32'h0, 2'b00, 0, 0, 32'h12345678, KRd,  32'h300, 2'b00, 32'h12345678));
        vecs.push_back(mk(1, 0, 32'h100, 32'h0, 2'b00, 0, 0, 32'h0,        KNone, 32'h0,  2'b00, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 32'h500, 32'h0, 2'b00, 0, 1, 32'hCAFEF00D, KRd,  32'h500, 2'b00, 32'hCAFEF00D));
        vecs.push_back(mk(1, 0, 32'h500, 32'h0, 2'b00, 0, 0, 32'h0,        KNone, 32'h0,  2'b00, 32'hCAFEF00D));
        vecs.push_back(mk(1, 0, 32'h100, 32'h0, 2'b00, 0, 0, 32'hDEADBEEF, KRd,  32'h100, 2'b00, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 32'h101, 32'h0, 2'b01, 0, 1, 32'h0000BEAD, KRd,  32'h101, 2'b01, 32'h0000BEAD));
        vecs.push_back(mk(1, 0, 32'h100, 32'h0, 2'b00, 0, 0, 32'h0,        KNone, 32'h0,  2'b00, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 32'h206, 32'h0, 2'b01, 1, 0, 32'h80010000, KRd,  32'h204, 2'b00, 32'hFFFF8001));
        vecs.push_back(mk(1, 0, 32'h207, 32'h0, 2'b10, 0, 0, 32'h0,        KNone, 32'h0,  2'b00, 32'h00000080));
        vecs.push_back(mk(1, 1, 32'h204, 32'h11223344, 2'b00, 0, 0, 32'h0, KWr,  32'h204, 2'b00, 32'h0));
        vecs.push_back(mk(1, 0, 32'h204, 32'h0, 2'b00, 0, 0, 32'h0,        KNone, 32'h0,  2'b00, 32'h11223344));
        vecs.push_back(mk(1, 0, 32'h100, 32'h0, 2'b11, 0, 0, 32'h0,        KNone, 32'h0,  2'b00, 32'h0));
        vecs.push_back(mk(0, 1, 32'h102, 32'h55, 2'b00, 0, 0, 32'h0,       KWr,  32'h102, 2'b00, 32'h0));
        vecs.push_back(mk(1, 0, 32'h100, 32'h0, 2'b00, 0, 0, 32'h0,        KNone, 32'h0,  2'b00, 32'hDEADBEEF));

        for (int i = 0; i < vecs.size(); i++) begin
            cur_id = i;
            run_vec(vecs[i]);
            if (i == 1) begin
                check("hits_after_first_pair", HitCount, 32'd1);
                check("misses_after_first_pair", MissCount, 32'd1);
            end
        end
        cur_id = 100;
        check("hits_total", HitCount, 32'd11);
        check("misses_total", MissCount, 32'd7);

        // Reset in the middle of a fill abandons it and clears the cache.
        cur_id = 200;
        ReqRead = 1'b1; ReqAddress = 32'h600; SizeSrc = 2'b00;
        @(negedge clk);
        check("miss_stall", {31'd0, Stall}, 32'd1);
        @(negedge clk);
        check("fill_memread", {31'd0, MemRead}, 32'd1);
        check("fill_addr", MemAddress, 32'h600);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_fill_memread", {31'd0, MemRead}, 32'd0);
        check("rst_fill_stall", {31'd0, Stall}, 32'd0);
        check("rst_fill_hits", HitCount, 32'd0);
        check("rst_fill_misses", MissCount, 32'd0);
        idle_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cur_id = 201;
        run_vec(mk(1, 0, 32'h100, 32'h0, 2'b00, 0, 1, 32'h0BADF00D, KRd, 32'h100, 2'b00,
                   32'h0BADF00D));
        check("post_rst_misses", MissCount, 32'd1);
        check("post_rst_hits", HitCount, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
